// File: rtl/u_mask_iter.sv
// ---------------------------------------------------------------------------
// u_mask_iter
//   Serialises the positions of a bit vector. A W-bit vector is accepted,
//   normalised so that a 1 marks a position to emit (bits equal to
//   MATCH_BIT), and then one beat per marked position is produced, lowest
//   index first (LSB=1) or highest index first (LSB=0). A vector with no
//   marked position still produces one beat flagged as empty.
//
// Parameters
//   W          vector width (>= 2)
//   MATCH_BIT  bit value whose positions are emitted
//   LSB        1: ascending index order, 0: descending index order
//
// Ports
//   i_clk, i_arst_n   clock, asynchronous active-low reset
//   i_in_vld/o_in_rdy input vector handshake, i_in_x is the vector
//   o_out_vld/i_out_rdy output beat handshake
//   o_out_idx         index of the current marked bit
//   o_out_last        final beat of the current vector
//   o_out_empty       vector held no marked bit (index reads 0)
//   o_busy            a vector is held
// ---------------------------------------------------------------------------
module u_mask_iter #(
  parameter int       W         = 16,
  parameter bit       MATCH_BIT = 1'b1,
  parameter bit       LSB       = 1'b1,
  localparam int      IW        = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_in_vld,
  output logic          o_in_rdy,
  input  logic [W-1:0]  i_in_x,
  output logic          o_out_vld,
  input  logic          i_out_rdy,
  output logic [IW-1:0] o_out_idx,
  output logic          o_out_last,
  output logic          o_out_empty,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
    logic          empty;
  } beat_t;

  state_t        state, state_nxt;
  logic [W-1:0]  p, p_nxt;
  logic [W-1:0]  norm;
  logic [IW-1:0] enc_idx;
  logic          p_one;
  logic          in_acc;
  logic          out_hs;
  beat_t         beat;

  // Normalise so that a 1 always marks a position still to emit.
  assign norm = MATCH_BIT ? i_in_x : ~i_in_x;

  // Priority encoder over the pending bits. The loop direction makes the
  // last hit win: scanning downward leaves the lowest set bit, upward the
  // highest. p is zero outside SCAN, so the encoder then returns 0.
  always_comb begin
    enc_idx = '0;
    if (LSB) begin
      for (int i = W - 1; i >= 0; i--)
        if (p[i]) enc_idx = IW'(i);
    end else begin
      for (int i = 0; i < W; i++)
        if (p[i]) enc_idx = IW'(i);
    end
  end

  // Exactly one pending bit left: this beat closes the vector.
  assign p_one = (p != '0) && ((p & (p - W'(1))) == '0);

  // Beat fields come straight from registered state so they stay stable
  // while the consumer stalls.
  always_comb begin
    beat       = '0;
    unique case (state)
      SCAN: begin
        beat.idx  = enc_idx;
        beat.last = p_one;
      end
      EMPTY: begin
        beat.last  = 1'b1;
        beat.empty = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_out_vld   = (state != IDLE);
  assign o_out_idx   = beat.idx;
  assign o_out_last  = beat.last;
  assign o_out_empty = beat.empty;
  assign o_busy      = (state != IDLE);

  // Accept is allowed while the final beat is leaving, giving back-to-back
  // vectors with no bubble. This makes i_out_rdy -> o_in_rdy combinational.
  assign o_in_rdy = (state == IDLE) | (o_out_vld & o_out_last & i_out_rdy);
  assign in_acc   = i_in_vld & o_in_rdy;
  assign out_hs   = o_out_vld & i_out_rdy;

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    unique case (state)
      IDLE: ;
      SCAN: begin
        if (out_hs) begin
          if (p_one) begin
            state_nxt = IDLE;
            p_nxt     = '0;
          end else begin
            p_nxt = p & ~(W'(1) << enc_idx);
          end
        end
      end
      EMPTY: begin
        if (out_hs) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        p_nxt     = '0;
      end
    endcase
    // A new vector overrides whatever the current state decided; in_acc
    // is only possible from IDLE or on the closing handshake.
    if (in_acc) begin
      p_nxt     = norm;
      state_nxt = (norm == '0) ? EMPTY : SCAN;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      p     <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
    end
  end

endmodule

// File: tb/tb_u_mask_iter.sv
// Directed bench for u_mask_iter. Three instances cover the ascending,
// descending and MATCH_BIT=0 configurations at W=8. Inputs change on the
// falling edge; outputs are checked 1 time unit later, before the next
// rising edge.
module tb_u_mask_iter;

  logic clk;
  logic arst_n;

  // d1: W=8, MATCH=1, LSB=1
  logic       vld1, irdy1, ovld1, ordy1, last1, empty1, busy1;
  logic [7:0] x1;
  logic [2:0] idx1;
  // d2: W=8, MATCH=1, LSB=0
  logic       vld2, irdy2, ovld2, ordy2, last2, empty2, busy2;
  logic [7:0] x2;
  logic [2:0] idx2;
  // d3: W=8, MATCH=0, LSB=1
  logic       vld3, irdy3, ovld3, ordy3, last3, empty3, busy3;
  logic [7:0] x3;
  logic [2:0] idx3;

  int checks = 0;
  int passes = 0;

  u_mask_iter #(.W(8), .MATCH_BIT(1'b1), .LSB(1'b1)) d1 (
    .i_clk(clk), .i_arst_n(arst_n), .i_in_vld(vld1), .o_in_rdy(irdy1),
    .i_in_x(x1), .o_out_vld(ovld1), .i_out_rdy(ordy1), .o_out_idx(idx1),
    .o_out_last(last1), .o_out_empty(empty1), .o_busy(busy1));

  u_mask_iter #(.W(8), .MATCH_BIT(1'b1), .LSB(1'b0)) d2 (
    .i_clk(clk), .i_arst_n(arst_n), .i_in_vld(vld2), .o_in_rdy(irdy2),
    .i_in_x(x2), .o_out_vld(ovld2), .i_out_rdy(ordy2), .o_out_idx(idx2),
    .o_out_last(last2), .o_out_empty(empty2), .o_busy(busy2));

  u_mask_iter #(.W(8), .MATCH_BIT(1'b0), .LSB(1'b1)) d3 (
    .i_clk(clk), .i_arst_n(arst_n), .i_in_vld(vld3), .o_in_rdy(irdy3),
    .i_in_x(x3), .o_out_vld(ovld3), .i_out_rdy(ordy3), .o_out_idx(idx3),
    .o_out_last(last3), .o_out_empty(empty3), .o_busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs may then be changed).
  task automatic fall();
    @(negedge clk);
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    vld1 = 0; x1 = '0; ordy1 = 0;
    vld2 = 0; x2 = '0; ordy2 = 0;
    vld3 = 0; x3 = '0; ordy3 = 0;

    // ---- reset state
    fall(); settle();
    chk("rst_vld",   ovld1,  0);
    chk("rst_irdy",  irdy1,  1);
    chk("rst_busy",  busy1,  0);
    chk("rst_idx",   idx1,   0);
    chk("rst_last",  last1,  0);
    chk("rst_empty", empty1, 0);
    fall(); arst_n = 1'b1;

    // ---- 1: ascending, x=1001_0100 -> 2,4,7
    fall(); vld1 = 1; x1 = 8'b1001_0100; ordy1 = 1; settle();
    chk("t1_irdy_idle", irdy1, 1);
    chk("t1_vld_idle",  ovld1, 0);
    fall(); vld1 = 0; x1 = 8'hAA; settle();
    chk("t1_b0_vld",   ovld1,  1);
    chk("t1_b0_idx",   idx1,   2);
    chk("t1_b0_last",  last1,  0);
    chk("t1_b0_empty", empty1, 0);
    chk("t1_b0_busy",  busy1,  1);
    fall(); settle();
    chk("t1_b1_idx",  idx1,  4);
    chk("t1_b1_last", last1, 0);
    fall(); settle();
    chk("t1_b2_idx",  idx1,  7);
    chk("t1_b2_last", last1, 1);
    chk("t1_b2_irdy", irdy1, 1);
    fall(); settle();
    chk("t1_done_vld",  ovld1, 0);
    chk("t1_done_busy", busy1, 0);

    // ---- 2: descending, x=FF -> 7..0, 8 beats
    fall(); vld2 = 1; x2 = 8'hFF; ordy2 = 1;
    fall(); vld2 = 0; settle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_b%0d_vld", k),  ovld2, 1);
      chk($sformatf("t2_b%0d_idx", k),  idx2,  32'(7 - k));
      chk($sformatf("t2_b%0d_last", k), last2, (k == 7) ? 1 : 0);
      fall(); settle();
    end
    chk("t2_done_vld",  ovld2, 0);
    chk("t2_done_busy", busy2, 0);

    // ---- 3: MATCH_BIT=0, x=FE -> idx 0; then x=FF -> empty beat
    fall(); vld3 = 1; x3 = 8'hFE; ordy3 = 1;
    fall(); vld3 = 0; settle();
    chk("t3a_vld",   ovld3,  1);
    chk("t3a_idx",   idx3,   0);
    chk("t3a_last",  last3,  1);
    chk("t3a_empty", empty3, 0);
    fall(); vld3 = 1; x3 = 8'hFF; settle();
    chk("t3a_done", ovld3, 0);
    fall(); vld3 = 0; settle();
    chk("t3b_vld",   ovld3,  1);
    chk("t3b_idx",   idx3,   0);
    chk("t3b_last",  last3,  1);
    chk("t3b_empty", empty3, 1);
    fall(); settle();
    chk("t3b_done", busy3, 0);

    // ---- 4: backpressure, x=81, consumer stalls 3 cycles
    fall(); vld1 = 1; x1 = 8'h81; ordy1 = 0;
    fall(); vld1 = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t4_hold%0d_vld", k),  ovld1, 1);
      chk($sformatf("t4_hold%0d_idx", k),  idx1,  0);
      chk($sformatf("t4_hold%0d_last", k), last1, 0);
      chk($sformatf("t4_hold%0d_irdy", k), irdy1, 0);
      fall();
    end
    ordy1 = 1; settle();
    chk("t4_rel_idx",  idx1,  0);
    chk("t4_rel_irdy", irdy1, 0);
    fall(); settle();
    chk("t4_b1_idx",  idx1,  7);
    chk("t4_b1_last", last1, 1);
    fall(); settle();
    chk("t4_done", ovld1, 0);

    // ---- 5: back-to-back x=01 then x=02, no bubble
    vld1 = 1; x1 = 8'h01;
    fall(); x1 = 8'h02; settle();
    chk("t5_b0_idx",  idx1,  0);
    chk("t5_b0_last", last1, 1);
    chk("t5_b0_irdy", irdy1, 1);
    fall(); vld1 = 0; settle();
    chk("t5_b1_vld",  ovld1, 1);
    chk("t5_b1_idx",  idx1,  1);
    chk("t5_b1_last", last1, 1);
    fall(); settle();
    chk("t5_done", ovld1, 0);

    // ---- 6: reset mid-scan, x=0F
    vld1 = 1; x1 = 8'h0F;
    fall(); vld1 = 0; settle();
    chk("t6_b0_idx", idx1, 0);
    fall(); settle();
    chk("t6_b1_idx", idx1, 1);
    arst_n = 1'b0; settle();
    chk("t6_rst_vld",  ovld1, 0);
    chk("t6_rst_busy", busy1, 0);
    fall(); arst_n = 1'b1; settle();
    chk("t6_rel_irdy", irdy1, 1);
    chk("t6_rel_vld",  ovld1, 0);
    fall(); settle();
    chk("t6_stale_vld", ovld1, 0);
    fall(); settle();
    chk("t6_stale2_vld", ovld1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
